// File: rtl/if_stage.sv
// Instruction-fetch stage: takes the PC from pre-IF, buffers SRAM read data,
// flags misaligned-PC AdEL and drops stale responses left in flight by a flush.
module if_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        pfs_to_fs_valid,
  input  logic [64:0] pfs_to_fs_bus,
  output logic        fs_allowin,
  output logic        fs_valid,
  output logic        fs_inst_buff_full,
  input  logic [31:0] inst_sram_rdata,
  input  logic        inst_sram_data_ok,
  input  logic        inst_sram_data_waiting,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  input  logic        ws_eret,
  input  logic        ws_ex
);

  logic        fs_valid_q,  fs_valid_d;
  logic [31:0] fs_pc_q,     fs_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_inst_q,  buf_inst_d;
  logic        fs_adel_q,   fs_adel_d;
  logic [1:0]  drop_cnt_q,  drop_cnt_d;

  logic        flush;
  logic        data_hit;
  logic        fs_ready_go;
  logic        accept;
  logic        leave;
  logic [2:0]  drop_sum;
  logic [31:0] fs_inst;

  assign flush       = ws_eret | ws_ex;
  assign data_hit    = inst_sram_data_ok && (drop_cnt_q == 2'd0);
  assign fs_ready_go = buf_valid_q || data_hit;

  assign fs_allowin        = !fs_valid_q || (fs_ready_go && ds_allowin);
  assign fs_valid          = fs_valid_q;
  assign fs_to_ds_valid    = fs_valid_q && fs_ready_go && !flush;
  assign fs_inst_buff_full = fs_valid_q && buf_valid_q && (drop_cnt_q == 2'd0);

  assign fs_inst      = fs_adel_q   ? '0 :
                        buf_valid_q ? buf_inst_q : inst_sram_rdata;
  assign fs_to_ds_bus = {fs_adel_q, fs_inst, fs_pc_q};

  assign accept = pfs_to_fs_valid && fs_allowin;
  assign leave  = fs_valid_q && fs_ready_go && ds_allowin;

  always_comb begin
    fs_valid_d  = fs_valid_q;
    fs_pc_d     = fs_pc_q;
    buf_valid_d = buf_valid_q;
    buf_inst_d  = buf_inst_q;
    fs_adel_d   = fs_adel_q;
    drop_cnt_d  = drop_cnt_q;

    // Responses still owed after a flush: our own pending fetch plus pre-IF's,
    // minus any that arrive on the flush cycle itself; clamped to [0,3].
    drop_sum = {1'b0, drop_cnt_q}
             + {2'b00, fs_valid_q && !buf_valid_q}
             + {2'b00, inst_sram_data_waiting};
    if (inst_sram_data_ok && (drop_sum != 3'd0))
      drop_sum = drop_sum - 3'd1;

    if (flush) begin
      fs_valid_d  = 1'b0;
      buf_valid_d = 1'b0;
      fs_adel_d   = 1'b0;
      drop_cnt_d  = (drop_sum > 3'd3) ? 2'd3 : drop_sum[1:0];
    end else begin
      if ((drop_cnt_q != 2'd0) && inst_sram_data_ok)
        drop_cnt_d = drop_cnt_q - 2'd1;

      if (accept) begin
        fs_valid_d  = 1'b1;
        fs_pc_d     = pfs_to_fs_bus[31:0];
        fs_adel_d   = (pfs_to_fs_bus[1:0] != 2'b00);
        buf_valid_d = pfs_to_fs_bus[64];
        buf_inst_d  = pfs_to_fs_bus[63:32];
      end else if (leave) begin
        fs_valid_d  = 1'b0;
        buf_valid_d = 1'b0;
      end else if (fs_valid_q && !buf_valid_q && data_hit) begin
        buf_valid_d = 1'b1;
        buf_inst_d  = inst_sram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q  <= 1'b0;
      fs_pc_q     <= '0;
      buf_valid_q <= 1'b0;
      buf_inst_q  <= '0;
      fs_adel_q   <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      fs_valid_q  <= fs_valid_d;
      fs_pc_q     <= fs_pc_d;
      buf_valid_q <= buf_valid_d;
      buf_inst_q  <= buf_inst_d;
      fs_adel_q   <= fs_adel_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table for the corner cases,
// then random traffic checked against a behavioural reference model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        pfs_to_fs_valid;
  logic [64:0] pfs_to_fs_bus;
  logic        fs_allowin;
  logic        fs_valid;
  logic        fs_inst_buff_full;
  logic [31:0] inst_sram_rdata;
  logic        inst_sram_data_ok;
  logic        inst_sram_data_waiting;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        ws_eret;
  logic        ws_ex;

  if_stage dut (
    .clk                    (clk),
    .reset                  (reset),
    .pfs_to_fs_valid        (pfs_to_fs_valid),
    .pfs_to_fs_bus          (pfs_to_fs_bus),
    .fs_allowin             (fs_allowin),
    .fs_valid               (fs_valid),
    .fs_inst_buff_full      (fs_inst_buff_full),
    .inst_sram_rdata        (inst_sram_rdata),
    .inst_sram_data_ok      (inst_sram_data_ok),
    .inst_sram_data_waiting (inst_sram_data_waiting),
    .ds_allowin             (ds_allowin),
    .fs_to_ds_valid         (fs_to_ds_valid),
    .fs_to_ds_bus           (fs_to_ds_bus),
    .ws_eret                (ws_eret),
    .ws_ex                  (ws_ex)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        rst, pv;
    logic [64:0] pbus;
    logic [31:0] rdata;
    logic        ok, wt, dsa, eret, ex;
    logic        chk;
    logic [3:0]  eflags;   // {allowin, valid, to_ds_valid, buff_full}
    logic        chkbus;
    logic [64:0] ebus;
  } vec_t;

  vec_t tbl[$];
  int   vectors = 0;
  int   errors  = 0;

  // Reference model state
  bit          m_valid, m_have, m_adel;
  logic [31:0] m_pc, m_inst;
  int          m_drop;

  function automatic logic [64:0] mkbus(input logic top, input logic [31:0] inst,
                                        input logic [31:0] pc);
    return {top, inst, pc};
  endfunction

  task automatic add(input string nm, input logic rst, input logic pv,
                     input logic [64:0] pbus, input logic [31:0] rdata,
                     input logic ok, input logic wt, input logic dsa,
                     input logic eret, input logic ex, input logic chk,
                     input logic [3:0] ef, input logic chkbus,
                     input logic [64:0] ebus);
    vec_t v;
    v.nm = nm; v.rst = rst; v.pv = pv; v.pbus = pbus; v.rdata = rdata;
    v.ok = ok; v.wt = wt; v.dsa = dsa; v.eret = eret; v.ex = ex;
    v.chk = chk; v.eflags = ef; v.chkbus = chkbus; v.ebus = ebus;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset                  = v.rst;
    pfs_to_fs_valid        = v.pv;
    pfs_to_fs_bus          = v.pbus;
    inst_sram_rdata        = v.rdata;
    inst_sram_data_ok      = v.ok;
    inst_sram_data_waiting = v.wt;
    ds_allowin             = v.dsa;
    ws_eret                = v.eret;
    ws_ex                  = v.ex;
  endtask

  task automatic compare(input string nm, input logic [3:0] ef,
                         input logic chkbus, input logic [64:0] ebus);
    logic [3:0] af;
    af = {fs_allowin, fs_valid, fs_to_ds_valid, fs_inst_buff_full};
    vectors++;
    if (af !== ef || (chkbus && fs_to_ds_bus !== ebus)) begin
      errors++;
      $display("FAIL %s: got flags=%b bus=%h, want flags=%b bus=%h%s",
               nm, af, fs_to_ds_bus, ef, ebus, chkbus ? "" : " (bus unchecked)");
    end
  endtask

  // Next-state rules of the fetch stage, stated at transaction level.
  task automatic model_step(input vec_t v);
    bit hit, ready, accept, leave;
    int owed;
    hit    = v.ok && (m_drop == 0);
    ready  = m_have || hit;
    accept = v.pv && (!m_valid || (ready && v.dsa));
    leave  = m_valid && ready && v.dsa;
    if (v.rst) begin
      m_valid = 0; m_have = 0; m_adel = 0; m_drop = 0; m_pc = '0; m_inst = '0;
    end else if (v.eret || v.ex) begin
      owed = m_drop + ((m_valid && !m_have) ? 1 : 0) + (v.wt ? 1 : 0) - (v.ok ? 1 : 0);
      m_drop  = (owed < 0) ? 0 : (owed > 3) ? 3 : owed;
      m_valid = 0; m_have = 0; m_adel = 0;
    end else begin
      if (m_drop > 0 && v.ok) m_drop = m_drop - 1;
      if (accept) begin
        m_valid = 1;
        m_pc    = v.pbus[31:0];
        m_adel  = (v.pbus[31:0] % 4) != 0;
        m_have  = v.pbus[64];
        m_inst  = v.pbus[63:32];
      end else if (leave) begin
        m_valid = 0; m_have = 0;
      end else if (m_valid && !m_have && hit) begin
        m_have = 1; m_inst = v.rdata;
      end
    end
  endtask

  task automatic model_expect(input vec_t v, output logic [3:0] ef,
                              output logic [64:0] ebus);
    bit hit, ready;
    hit   = v.ok && (m_drop == 0);
    ready = m_have || hit;
    ef[3] = !m_valid || (ready && v.dsa);
    ef[2] = m_valid;
    ef[1] = m_valid && ready && !(v.eret || v.ex);
    ef[0] = m_valid && m_have && (m_drop == 0);
    ebus  = {m_adel, m_adel ? 32'h0 : (m_have ? m_inst : v.rdata), m_pc};
  endtask

  initial begin
    vec_t        v;
    logic [3:0]  ef;
    logic [64:0] eb;
    logic [31:0] pc;

    //   name        rst pv pbus                                   rdata        ok wt dsa er ex chk flags   cb bus
    add("rst0",     1, 0, '0,                                     32'h0,        0, 0, 1, 0, 0, 0, 4'b0000, 0, '0);
    add("reset",    1, 0, '0,                                     32'h0,        0, 0, 1, 0, 0, 1, 4'b1000, 1, '0);
    add("nf_acc",   0, 1, mkbus(0, 32'h0, 32'hBFC00000),          32'h0,        0, 0, 1, 0, 0, 1, 4'b1000, 0, '0);
    add("nf_wait",  0, 0, '0,                                     32'h0,        0, 0, 1, 0, 0, 1, 4'b0100, 0, '0);
    add("nf_data",  0, 0, '0,                                     32'h24080001, 1, 0, 1, 0, 0, 1, 4'b1110, 1,
        mkbus(0, 32'h24080001, 32'hBFC00000));
    add("st_acc",   0, 1, mkbus(0, 32'h0, 32'hBFC00004),          32'h0,        0, 0, 1, 0, 0, 1, 4'b1000, 0, '0);
    add("st_data",  0, 0, '0,                                     32'h11111111, 1, 0, 0, 0, 0, 1, 4'b0110, 1,
        mkbus(0, 32'h11111111, 32'hBFC00004));
    add("st_hold1", 0, 0, '0,                                     32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 4'b0111, 1,
        mkbus(0, 32'h11111111, 32'hBFC00004));
    add("st_hold2", 0, 0, '0,                                     32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 4'b0111, 1,
        mkbus(0, 32'h11111111, 32'hBFC00004));
    add("st_rel",   0, 0, '0,                                     32'hDEADBEEF, 0, 0, 1, 0, 0, 1, 4'b1111, 1,
        mkbus(0, 32'h11111111, 32'hBFC00004));
    add("pc_acc",   0, 1, mkbus(1, 32'hAABBCCDD, 32'hBFC00008),   32'h0,        0, 0, 1, 0, 0, 1, 4'b1000, 0, '0);
    add("pc_out",   0, 0, '0,                                     32'h0,        0, 0, 1, 0, 0, 1, 4'b1111, 1,
        mkbus(0, 32'hAABBCCDD, 32'hBFC00008));
    add("fl_acc",   0, 1, mkbus(0, 32'h0, 32'hBFC0000C),          32'h0,        0, 0, 1, 0, 0, 1, 4'b1000, 0, '0);
    add("fl_ex",    0, 0, '0,                                     32'h0,        0, 1, 1, 0, 1, 1, 4'b0100, 0, '0);
    add("fl_drop1", 0, 1, mkbus(0, 32'h0, 32'hBFC00380),          32'h12345678, 1, 0, 1, 0, 0, 1, 4'b1000, 0, '0);
    add("fl_drop2", 0, 0, '0,                                     32'h87654321, 1, 0, 1, 0, 0, 1, 4'b0100, 0, '0);
    add("fl_new",   0, 0, '0,                                     32'h00000000, 1, 0, 1, 0, 0, 1, 4'b1110, 1,
        mkbus(0, 32'h0, 32'hBFC00380));
    add("ad_acc",   0, 1, mkbus(0, 32'h0, 32'hBFC00002),          32'h0,        0, 0, 1, 0, 0, 1, 4'b1000, 0, '0);
    add("ad_data",  0, 0, '0,                                     32'h55555555, 1, 0, 1, 0, 0, 1, 4'b1110, 1,
        mkbus(1, 32'h0, 32'hBFC00002));
    add("er_acc",   0, 1, mkbus(1, 32'hAABBCCDD, 32'hBFC00010),   32'h0,        0, 0, 1, 1, 0, 1, 4'b1000, 0, '0);
    add("er_after", 0, 0, '0,                                     32'h0,        0, 0, 1, 0, 0, 1, 4'b1000, 0, '0);
    add("mr_acc",   0, 1, mkbus(0, 32'h0, 32'hBFC00014),          32'h0,        0, 0, 1, 0, 0, 1, 4'b1000, 0, '0);
    add("mr_rst",   1, 0, '0,                                     32'h0,        0, 0, 1, 0, 0, 1, 4'b0100, 0, '0);
    add("mr_after", 0, 0, '0,                                     32'h0,        0, 0, 1, 0, 0, 1, 4'b1000, 0, '0);

    v = tbl[0];
    drive(v);
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(negedge clk);
      if (tbl[i].chk) compare(tbl[i].nm, tbl[i].eflags, tbl[i].chkbus, tbl[i].ebus);
      @(posedge clk); #1;
    end

    // Random phase: the model starts from reset.
    m_valid = 0; m_have = 0; m_adel = 0; m_drop = 0; m_pc = '0; m_inst = '0;
    v.rst = 1; v.pv = 0; v.pbus = '0; v.rdata = '0; v.ok = 0; v.wt = 0;
    v.dsa = 1; v.eret = 0; v.ex = 0; v.nm = "rnd";
    drive(v);
    @(posedge clk); #1;

    for (int n = 0; n < 2000; n++) begin
      pc = $urandom;
      if ($urandom_range(3) != 0) pc[1:0] = 2'b00;
      v.rst   = ($urandom_range(99) == 0);
      v.pv    = $urandom_range(1);
      v.pbus  = {1'($urandom_range(1)), 32'($urandom), pc};
      v.rdata = $urandom;
      v.ok    = ($urandom_range(9) < 4);
      v.wt    = ($urandom_range(9) < 3);
      v.dsa   = ($urandom_range(9) < 7);
      v.eret  = ($urandom_range(29) == 0);
      v.ex    = ($urandom_range(29) == 0);
      drive(v);
      @(negedge clk);
      model_expect(v, ef, eb);
      compare("rnd", ef, ef[2], eb);
      @(posedge clk);
      model_step(v);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
